// File: rtl/mc_ctrl_pkg.sv
// Shared control encodings for the multi-cycle MIPS sequencer: states, opcode/funct fields,
// datapath select codes and the instruction classes produced by the decoder.
package mc_ctrl_pkg;

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   localparam logic [4:0] RT_BLTZ = 5'd0;
   localparam logic [4:0] RT_BGEZ = 5'd1;

   // Branch ALUOps make the ALU drive Zero=1 exactly when the branch is taken.
   localparam logic [4:0] ALU_NOP  = 5'd0;
   localparam logic [4:0] ALU_ADD  = 5'd1;
   localparam logic [4:0] ALU_SUB  = 5'd2;
   localparam logic [4:0] ALU_AND  = 5'd3;
   localparam logic [4:0] ALU_OR   = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_NOR  = 5'd6;
   localparam logic [4:0] ALU_SLT  = 5'd7;
   localparam logic [4:0] ALU_SLTU = 5'd8;
   localparam logic [4:0] ALU_LUI  = 5'd9;
   localparam logic [4:0] ALU_SLL  = 5'd10;
   localparam logic [4:0] ALU_SRL  = 5'd11;
   localparam logic [4:0] ALU_SRA  = 5'd12;
   localparam logic [4:0] ALU_BNE  = 5'd13;
   localparam logic [4:0] ALU_BLEZ = 5'd14;
   localparam logic [4:0] ALU_BGTZ = 5'd15;
   localparam logic [4:0] ALU_BGEZ = 5'd16;
   localparam logic [4:0] ALU_BLTZ = 5'd17;
   localparam logic [4:0] ALU_SLLV = 5'd18;
   localparam logic [4:0] ALU_SRLV = 5'd19;
   localparam logic [4:0] ALU_SRAV = 5'd20;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   typedef enum logic [3:0] {
      IC_ALU     = 4'd0,
      IC_LOAD    = 4'd1,
      IC_STORE   = 4'd2,
      IC_BRANCH  = 4'd3,
      IC_JUMP    = 4'd4,
      IC_JR      = 4'd5,
      IC_LINK    = 4'd6,
      IC_LINKR   = 4'd7,
      IC_ILLEGAL = 4'd8
   } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Static decode of the latched IR fields into datapath selects and an instruction class.
// Latency: purely combinational. Backpressure: none, outputs follow Op/Funct/Rt.
// Unsupported encodings report IC_ILLEGAL with inert selects.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic [4:0] Rt,
   output logic [3:0] iclass,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUSrc,
   output logic       ALUSrc2,
   output logic       EXTOp,
   output logic [4:0] ALUOp
);

   iclass_t cls;

   always_comb begin
      cls      = IC_ILLEGAL;
      RegDst   = RD_RT;
      MemtoReg = WD_ALU;
      ALUSrc   = 1'b0;
      ALUSrc2  = 1'b0;
      EXTOp    = 1'b0;
      ALUOp    = ALU_NOP;
      case (Op)
         OP_RTYPE: begin
            cls    = IC_ALU;
            RegDst = RD_RD;
            case (Funct)
               F_ADD, F_ADDU: ALUOp = ALU_ADD;
               F_SUB, F_SUBU: ALUOp = ALU_SUB;
               F_AND:  ALUOp = ALU_AND;
               F_OR:   ALUOp = ALU_OR;
               F_XOR:  ALUOp = ALU_XOR;
               F_NOR:  ALUOp = ALU_NOR;
               F_SLT:  ALUOp = ALU_SLT;
               F_SLTU: ALUOp = ALU_SLTU;
               F_SLL:  begin ALUOp = ALU_SLL; ALUSrc2 = 1'b1; end
               F_SRL:  begin ALUOp = ALU_SRL; ALUSrc2 = 1'b1; end
               F_SRA:  begin ALUOp = ALU_SRA; ALUSrc2 = 1'b1; end
               F_SLLV: ALUOp = ALU_SLLV;
               F_SRLV: ALUOp = ALU_SRLV;
               F_SRAV: ALUOp = ALU_SRAV;
               F_JR:   cls = IC_JR;
               F_JALR: begin cls = IC_LINKR; MemtoReg = WD_PC4; end
               default: begin cls = IC_ILLEGAL; RegDst = RD_RT; end
            endcase
         end
         OP_REGIMM: begin
            cls   = IC_BRANCH;
            EXTOp = 1'b1;
            case (Rt)
               RT_BLTZ: ALUOp = ALU_BLTZ;
               RT_BGEZ: ALUOp = ALU_BGEZ;
               default: begin cls = IC_ILLEGAL; EXTOp = 1'b0; end
            endcase
         end
         OP_BEQ:   begin cls = IC_BRANCH; EXTOp = 1'b1; ALUOp = ALU_SUB;  end
         OP_BNE:   begin cls = IC_BRANCH; EXTOp = 1'b1; ALUOp = ALU_BNE;  end
         OP_BLEZ:  begin cls = IC_BRANCH; EXTOp = 1'b1; ALUOp = ALU_BLEZ; end
         OP_BGTZ:  begin cls = IC_BRANCH; EXTOp = 1'b1; ALUOp = ALU_BGTZ; end
         OP_J:     cls = IC_JUMP;
         OP_JAL:   begin cls = IC_LINK; RegDst = RD_RA; MemtoReg = WD_PC4; end
         OP_ADDI, OP_ADDIU: begin cls = IC_ALU; ALUSrc = 1'b1; EXTOp = 1'b1; ALUOp = ALU_ADD;  end
         OP_SLTI:  begin cls = IC_ALU; ALUSrc = 1'b1; EXTOp = 1'b1; ALUOp = ALU_SLT;  end
         OP_SLTIU: begin cls = IC_ALU; ALUSrc = 1'b1; EXTOp = 1'b1; ALUOp = ALU_SLTU; end
         OP_ANDI:  begin cls = IC_ALU; ALUSrc = 1'b1; ALUOp = ALU_AND; end
         OP_ORI:   begin cls = IC_ALU; ALUSrc = 1'b1; ALUOp = ALU_OR;  end
         OP_XORI:  begin cls = IC_ALU; ALUSrc = 1'b1; ALUOp = ALU_XOR; end
         OP_LUI:   begin cls = IC_ALU; ALUSrc = 1'b1; ALUOp = ALU_LUI; end
         OP_LW:    begin cls = IC_LOAD;  ALUSrc = 1'b1; EXTOp = 1'b1; ALUOp = ALU_ADD; MemtoReg = WD_MEM; end
         OP_SW:    begin cls = IC_STORE; ALUSrc = 1'b1; EXTOp = 1'b1; ALUOp = ALU_ADD; end
         default:  cls = IC_ILLEGAL;
      endcase
   end

   assign iclass = cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with strobes, commit pulse and retired-instruction count.
// Latency: R/imm 4, lw 5, sw 4, branch/j/jr 3, jal/jalr 4 cycles; each mem_ready=0 cycle adds 1.
// Backpressure: IF and MEM hold their request stable until mem_ready.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic [4:0]       Rt,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic             ALUSrc,
   output logic             ALUSrc2,
   output logic             EXTOp,
   output logic [4:0]       ALUOp,
   output logic [1:0]       NPCOp,
   output logic             illegal,
   output logic             retire,
   output logic [CNT_W-1:0] instret
);

   logic [2:0] state;
   logic [2:0] next_state;
   logic [3:0] iclass;
   iclass_t    cls;

   mc_ctrl_decode u_decode (
      .Op       (Op),
      .Funct    (Funct),
      .Rt       (Rt),
      .iclass   (iclass),
      .RegDst   (RegDst),
      .MemtoReg (MemtoReg),
      .ALUSrc   (ALUSrc),
      .ALUSrc2  (ALUSrc2),
      .EXTOp    (EXTOp),
      .ALUOp    (ALUOp)
   );

   assign cls = iclass_t'(iclass);

   always_comb begin
      next_state = state;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      NPCOp      = NPC_PLUS4;
      illegal    = 1'b0;
      if (rst) begin
         next_state = S_IF;
      end else begin
         case (state)
            S_IF: begin
               MemRead = 1'b1;
               if (mem_ready) begin
                  IRWrite    = 1'b1;
                  next_state = S_ID;
               end
            end
            S_ID: next_state = S_EX;
            S_EX: begin
               next_state = S_IF;
               case (cls)
                  IC_ALU, IC_LINK, IC_LINKR: next_state = S_WB;
                  IC_LOAD, IC_STORE:         next_state = S_MEM;
                  IC_BRANCH: begin
                     PCWrite = 1'b1;
                     NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
                  end
                  IC_JUMP: begin
                     PCWrite = 1'b1;
                     NPCOp   = NPC_JUMP;
                  end
                  IC_JR: begin
                     PCWrite = 1'b1;
                     NPCOp   = NPC_JR;
                  end
                  default: begin
                     // Unsupported encodings retire as a nop so the program keeps flowing.
                     illegal = 1'b1;
                     PCWrite = 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               IorD = 1'b1;
               if (cls == IC_LOAD) begin
                  MemRead = 1'b1;
                  if (mem_ready) next_state = S_WB;
               end else if (cls == IC_STORE) begin
                  MemWrite = 1'b1;
                  if (mem_ready) begin
                     PCWrite    = 1'b1;
                     next_state = S_IF;
                  end
               end else begin
                  next_state = S_IF;
               end
            end
            S_WB: begin
               RegWrite   = 1'b1;
               PCWrite    = 1'b1;
               next_state = S_IF;
               if (cls == IC_LINK)       NPCOp = NPC_JUMP;
               else if (cls == IC_LINKR) NPCOp = NPC_JR;
            end
            default: next_state = S_IF;
         endcase
      end
   end

   // Every PCWrite closes an instruction, so it doubles as the commit pulse.
   assign retire = PCWrite;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IF;
         instret <= '0;
      end else begin
         state <= next_state;
         if (retire) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle strobe vectors and select fields against hand-computed values.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  Op;
   logic [5:0]  Funct;
   logic [4:0]  Rt;
   logic        Zero;
   logic        mem_ready;
   logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
   logic [1:0]  RegDst, MemtoReg, NPCOp;
   logic        ALUSrc, ALUSrc2, EXTOp;
   logic [4:0]  ALUOp;
   logic        illegal, retire;
   logic [31:0] instret;
   logic [7:0]  strb;

   int n_chk  = 0;
   int n_fail = 0;

   mc_ctrl #(.CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .Op        (Op),
      .Funct     (Funct),
      .Rt        (Rt),
      .Zero      (Zero),
      .mem_ready (mem_ready),
      .PCWrite   (PCWrite),
      .IRWrite   (IRWrite),
      .IorD      (IorD),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .RegWrite  (RegWrite),
      .RegDst    (RegDst),
      .MemtoReg  (MemtoReg),
      .ALUSrc    (ALUSrc),
      .ALUSrc2   (ALUSrc2),
      .EXTOp     (EXTOp),
      .ALUOp     (ALUOp),
      .NPCOp     (NPCOp),
      .illegal   (illegal),
      .retire    (retire),
      .instret   (instret)
   );

   always #5 clk = ~clk;

   // {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, illegal, retire}
   assign strb = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, illegal, retire};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [7:0] exp);
      @(negedge clk);
      chk(tag, 32'(strb), 32'(exp));
   endtask

   task automatic adv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; Op = '0; Funct = '0; Rt = '0; Zero = 1'b0; mem_ready = 1'b1;
      adv();
      cyc("rst_strb", 8'h00);
      chk("rst_instret", instret, 32'd0);
      chk("rst_state", 32'(dut.state), 32'd0);
      adv();
      rst = 1'b0;

      // add
      Op = 6'h00; Funct = 6'h20;
      cyc("add_if", 8'b0101_0000); adv();
      cyc("add_id", 8'b0000_0000); adv();
      cyc("add_ex", 8'b0000_0000);
      chk("add_regdst", 32'(RegDst), 32'd1);
      chk("add_aluop", 32'(ALUOp), 32'd1);
      adv();
      cyc("add_wb", 8'b1000_0101);
      chk("add_npc", 32'(NPCOp), 32'd0);
      adv();
      chk("add_instret", instret, 32'd1);

      // lw with two stalled MEM cycles: 7 cycles total
      Op = 6'h23;
      cyc("lw_if", 8'b0101_0000); adv();
      cyc("lw_id", 8'b0000_0000); adv();
      cyc("lw_ex", 8'b0000_0000); adv();
      mem_ready = 1'b0;
      cyc("lw_mem0", 8'b0011_0000); adv();
      cyc("lw_mem1", 8'b0011_0000); adv();
      mem_ready = 1'b1;
      cyc("lw_mem2", 8'b0011_0000); adv();
      cyc("lw_wb", 8'b1000_0101);
      chk("lw_memtoreg", 32'(MemtoReg), 32'd1);
      chk("lw_regdst", 32'(RegDst), 32'd0);
      adv();
      chk("lw_instret", instret, 32'd2);

      // beq taken then not taken
      Op = 6'h04; Zero = 1'b1;
      cyc("beqt_if", 8'b0101_0000); adv();
      cyc("beqt_id", 8'b0000_0000); adv();
      cyc("beqt_ex", 8'b1000_0001);
      chk("beqt_npc", 32'(NPCOp), 32'd1);
      adv();
      chk("beqt_instret", instret, 32'd3);
      Zero = 1'b0;
      cyc("beqn_if", 8'b0101_0000); adv();
      cyc("beqn_id", 8'b0000_0000); adv();
      cyc("beqn_ex", 8'b1000_0001);
      chk("beqn_npc", 32'(NPCOp), 32'd0);
      adv();
      chk("beqn_instret", instret, 32'd4);

      // jal
      Op = 6'h03;
      cyc("jal_if", 8'b0101_0000); adv();
      cyc("jal_id", 8'b0000_0000); adv();
      cyc("jal_ex", 8'b0000_0000); adv();
      cyc("jal_wb", 8'b1000_0101);
      chk("jal_regdst", 32'(RegDst), 32'd2);
      chk("jal_memtoreg", 32'(MemtoReg), 32'd2);
      chk("jal_npc", 32'(NPCOp), 32'd2);
      adv();
      chk("jal_instret", instret, 32'd5);

      // j and jr commit in EX
      Op = 6'h02;
      cyc("j_if", 8'b0101_0000); adv();
      cyc("j_id", 8'b0000_0000); adv();
      cyc("j_ex", 8'b1000_0001);
      chk("j_npc", 32'(NPCOp), 32'd2);
      adv();
      Op = 6'h00; Funct = 6'h08;
      cyc("jr_if", 8'b0101_0000); adv();
      cyc("jr_id", 8'b0000_0000); adv();
      cyc("jr_ex", 8'b1000_0001);
      chk("jr_npc", 32'(NPCOp), 32'd3);
      adv();
      chk("jr_instret", instret, 32'd7);

      // srav: variable shift, no shamt operand
      Funct = 6'h07;
      cyc("srav_if", 8'b0101_0000); adv();
      cyc("srav_id", 8'b0000_0000); adv();
      cyc("srav_ex", 8'b0000_0000);
      chk("srav_aluop", 32'(ALUOp), 32'd20);
      chk("srav_alusrc2", 32'(ALUSrc2), 32'd0);
      adv();
      cyc("srav_wb", 8'b1000_0101); adv();
      chk("srav_instret", instret, 32'd8);

      // sw with IF stall, then reset while MEM is stalled
      Op = 6'h2B; mem_ready = 1'b0;
      cyc("sw_if_stall", 8'b0001_0000); adv();
      mem_ready = 1'b1;
      cyc("sw_if", 8'b0101_0000); adv();
      cyc("sw_id", 8'b0000_0000); adv();
      cyc("sw_ex", 8'b0000_0000); adv();
      mem_ready = 1'b0;
      cyc("sw_mem", 8'b0010_1000);
      rst = 1'b1;
      cyc("sw_rst", 8'b0000_0000); adv();
      rst = 1'b0;
      cyc("sw_after", 8'b0001_0000);
      chk("sw_after_state", 32'(dut.state), 32'd0);
      chk("sw_after_memwrite", 32'(MemWrite), 32'd0);
      chk("sw_after_pcwrite", 32'(PCWrite), 32'd0);
      chk("sw_after_instret", instret, 32'd0);
      adv();

      // illegal opcode retires as a nop
      Op = 6'h3F; mem_ready = 1'b1;
      cyc("ill_if", 8'b0101_0000); adv();
      cyc("ill_id", 8'b0000_0000); adv();
      cyc("ill_ex", 8'b1000_0011);
      chk("ill_npc", 32'(NPCOp), 32'd0);
      adv();
      mem_ready = 1'b0;
      cyc("ill_next", 8'b0001_0000);
      chk("ill_state", 32'(dut.state), 32'd0);
      chk("ill_instret", instret, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
